// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// The default width here matches the divider's CNT_W parameter default.
package clk_div_pkg;

  localparam int CNT_W_DEFAULT = 8;
  localparam int DIV_MIN       = 2;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/clk_div_if.sv
// Ratio-configuration handshake between config logic (master) and the divider (slave).
interface clk_div_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);

endinterface

// File: rtl/clk_div_cfg_slot.sv
// One-deep holding slot for a requested ratio: accepts, clamps and flags it, and
// keeps it pending until the divider applies it at a safe period boundary.
module clk_div_cfg_slot
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  clk_div_if.slave         cfg,
  input  logic             i_apply,
  output logic             o_pending,
  output logic [CNT_W-1:0] o_pend_div
);

  logic             r_pending;
  logic             r_cfg_err;
  logic [CNT_W-1:0] r_pend_div;
  logic             w_accept;
  logic             w_too_small;

  assign w_accept    = cfg.cfg_valid && !r_pending;
  assign w_too_small = (cfg.cfg_div < CNT_W'(DIV_MIN));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_pend_div <= CNT_W'(DIV_MIN);
    end else if (w_accept) begin
      r_pending  <= 1'b1;
      r_pend_div <= w_too_small ? CNT_W'(DIV_MIN) : cfg.cfg_div;
      r_cfg_err  <= w_too_small;
    end else if (i_apply) begin
      r_pending  <= 1'b0;
    end
  end

  assign cfg.cfg_ready = !r_pending;
  assign cfg.cfg_err   = r_cfg_err;
  assign o_pending     = r_pending;
  assign o_pend_div    = r_pend_div;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: registered clk_div, period-start tick,
// ratio changes and start/stop only at period boundaries so no pulse is ever truncated.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int RESET_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  clk_div_if.slave         cfg,
  output logic             clk_div,
  output logic             tick,
  output logic             active,
  output logic [CNT_W-1:0] cur_div
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [CNT_W-1:0] r_cur_div, w_cur_div_nxt;
  logic             r_clk_div, w_clk_div_nxt;
  logic             r_tick, w_tick_nxt;
  logic             w_start;
  logic             w_apply;
  logic             w_last;
  logic             w_pending;
  logic [CNT_W-1:0] w_pend_div;
  logic [CNT_W-1:0] w_count_inc;
  logic [CNT_W-1:0] w_half;

  clk_div_cfg_slot #(.CNT_W(CNT_W)) u_cfg_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cfg),
    .i_apply    (w_apply),
    .o_pending  (w_pending),
    .o_pend_div (w_pend_div)
  );

  assign w_last      = (r_count == r_cur_div - 1'b1);
  assign w_count_inc = r_count + 1'b1;
  // High phase is ceil(R/2) cycles, so odd ratios get the extra high cycle.
  assign w_half      = (r_cur_div >> 1) + {{(CNT_W-1){1'b0}}, r_cur_div[0]};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_clk_div_nxt = r_clk_div;
    w_tick_nxt    = 1'b0;
    w_start       = 1'b0;

    case (r_state)
      IDLE: if (en) begin
        w_state_nxt = RUN;
        w_start     = 1'b1;
      end
      RUN: if (w_last) begin
        if (en) w_start     = 1'b1;
        else    w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_start) begin
      w_count_nxt   = '0;
      w_clk_div_nxt = 1'b1;
      w_tick_nxt    = 1'b1;
    end else if (w_state_nxt == IDLE) begin
      w_count_nxt   = '0;
      w_clk_div_nxt = 1'b0;
    end else begin
      w_count_nxt   = w_count_inc;
      w_clk_div_nxt = (w_count_inc < w_half);
    end
  end

  // A pending ratio only lands where no period is in flight: idle, or a period start.
  assign w_apply       = w_pending && ((r_state == IDLE) || w_start);
  assign w_cur_div_nxt = w_apply ? w_pend_div : r_cur_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_cur_div <= CNT_W'(RESET_DIV);
      r_clk_div <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_cur_div <= w_cur_div_nxt;
      r_clk_div <= w_clk_div_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign clk_div = r_clk_div;
  assign tick    = r_tick;
  assign active  = (r_state == RUN);
  assign cur_div = r_cur_div;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: drives on and samples at the falling edge,
// compares against hand-derived waveforms with immediate assertions.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic clk_div, tick, active;
  div_t cur_div;
  int   n_tests = 0;
  int   n_fail  = 0;

  clk_div_if #(.CNT_W(8)) cfg_if ();

  clk_div_prog #(.CNT_W(8), .RESET_DIV(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cfg     (cfg_if),
    .clk_div (clk_div),
    .tick    (tick),
    .active  (active),
    .cur_div (cur_div)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the falling edge right after a period start; walks one full period.
  task automatic check_period(input string tag, input int r);
    for (int i = 0; i < r; i++) begin
      check({tag, "_tick"},   32'(tick),    32'(i == 0));
      check({tag, "_clkdiv"}, 32'(clk_div), 32'(i < (r + 1) / 2));
      check({tag, "_active"}, 32'(active),  32'd1);
      @(negedge clk);
    end
  endtask

  task automatic wait_tick(input string tag, input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < bound);
    check({tag, "_tick_seen"}, 32'(tick), 32'd1);
  endtask

  task automatic offer(input logic [7:0] div);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = div;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    repeat (2) @(negedge clk);
    check("rst_clkdiv", 32'(clk_div),          32'd0);
    check("rst_tick",   32'(tick),             32'd0);
    check("rst_active", 32'(active),           32'd0);
    check("rst_curdiv", 32'(cur_div),          32'd8);
    check("rst_ready",  32'(cfg_if.cfg_ready), 32'd1);
    check("rst_err",    32'(cfg_if.cfg_err),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_active", 32'(active), 32'd0);

    // 1: default ratio 8, first tick one cycle after en is sampled
    en = 1'b1;
    @(negedge clk);
    check_period("t1_p1", 8);
    check_period("t1_p2", 8);
    en = 1'b0;
    check_period("t1_p3", 8);
    check("t1_stop_active", 32'(active),  32'd0);
    check("t1_stop_clkdiv", 32'(clk_div), 32'd0);

    // 2: ratio 5 programmed while idle
    offer(8'd5);
    check("t2_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    check("t2_cur_old",   32'(cur_div),          32'd8);
    @(negedge clk);
    check("t2_cur_new",   32'(cur_div),          32'd5);
    check("t2_ready_hi",  32'(cfg_if.cfg_ready), 32'd1);
    en = 1'b1;
    @(negedge clk);
    check_period("t2_p1", 5);
    check_period("t2_p2", 5);

    // 3: back to 8, then accept 3 at count 2 of an 8-cycle period
    offer(8'd8);
    wait_tick("t3_to8", 20);
    check("t3_cur8", 32'(cur_div), 32'd8);
    repeat (2) @(negedge clk);
    offer(8'd3);
    check("t3_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    check("t3_cur_still8", 32'(cur_div), 32'd8);
    for (int c = 3; c < 8; c++) begin
      check("t3_tail_clkdiv", 32'(clk_div),          32'(c < 4));
      check("t3_tail_tick",   32'(tick),             32'd0);
      check("t3_tail_ready",  32'(cfg_if.cfg_ready), 32'd0);
      @(negedge clk);
    end
    check("t3_cur3",   32'(cur_div),          32'd3);
    check("t3_ready",  32'(cfg_if.cfg_ready), 32'd1);
    check_period("t3_p1", 3);
    check_period("t3_p2", 3);

    // 4: illegal ratio clamps to 2 and flags, a legal one clears the flag
    offer(8'd1);
    check("t4_err_set", 32'(cfg_if.cfg_err), 32'd1);
    wait_tick("t4_apply", 20);
    check("t4_cur2", 32'(cur_div), 32'd2);
    check_period("t4_p1", 2);
    check_period("t4_p2", 2);
    offer(8'd4);
    check("t4_err_clr", 32'(cfg_if.cfg_err), 32'd0);
    wait_tick("t4_apply4", 20);
    check("t4_cur4", 32'(cur_div), 32'd4);

    // 5: ratio 6, en dropped at count 1 finishes the period
    offer(8'd6);
    wait_tick("t5_apply", 20);
    check("t5_cur6", 32'(cur_div), 32'd6);
    @(negedge clk);
    en = 1'b0;
    for (int c = 2; c < 6; c++) begin
      @(negedge clk);
      check("t5_drain_active", 32'(active),  32'd1);
      check("t5_drain_clkdiv", 32'(clk_div), 32'(c < 3));
    end
    @(negedge clk);
    check("t5_idle_active", 32'(active),  32'd0);
    check("t5_idle_clkdiv", 32'(clk_div), 32'd0);
    check("t5_idle_tick",   32'(tick),    32'd0);
    en = 1'b1;
    @(negedge clk);
    check("t5_run2_tick", 32'(tick), 32'd1);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    for (int c = 3; c < 6; c++) begin
      check("t5_reraise_clkdiv", 32'(clk_div), 32'd0);
      check("t5_reraise_active", 32'(active),  32'd1);
      @(negedge clk);
    end
    check_period("t5_nogap", 6);

    // 6: asynchronous reset mid-period with a ratio pending
    offer(8'd3);
    check("t6_pending", 32'(cfg_if.cfg_ready), 32'd0);
    @(negedge clk);
    check("t6_pre_clkdiv", 32'(clk_div), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_clkdiv", 32'(clk_div),          32'd0);
    check("t6_rst_tick",   32'(tick),             32'd0);
    check("t6_rst_active", 32'(active),           32'd0);
    check("t6_rst_curdiv", 32'(cur_div),          32'd8);
    check("t6_rst_ready",  32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_period("t6_restart", 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
